dial_coprocessor: RTL and testbench

DIAL_COPROCESSOR -- requirements
Module: dial_coprocessor

---
 rtl/dial_coprocessor.sv | 143 ++++++++++++++
 tb/tb_dial_coprocessor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dial_coprocessor.sv
// Rotary dial coprocessor: applies L/R rotation commands to a circular dial,
// counting landings on zero and passes over zero, with a multi-cycle lap divider.
module dial_coprocessor #(
    parameter int WIDTH_DIN     = 128,
    parameter int WIDTH_DOUT    = 128,
    parameter int WIDTH_COMPUTE = 32,
    parameter int WIDTH_STEP    = 16,
    parameter int DIAL_SIZE     = 100,
    parameter int START_POS     = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH_DIN-1:0]  din,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  clear,
    input  logic [2:0]            sel,
    output logic [WIDTH_DOUT-1:0] dout,
    output logic                  dout_valid
);

    typedef enum logic [1:0] {IDLE, DIV, APPLY, DONE} state_t;

    localparam logic [WIDTH_STEP-1:0]    LP_SIZE_S  = WIDTH_STEP'(DIAL_SIZE);
    localparam logic [WIDTH_COMPUTE-1:0] LP_SIZE_C  = WIDTH_COMPUTE'(DIAL_SIZE);
    localparam logic [WIDTH_COMPUTE-1:0] LP_START_C = WIDTH_COMPUTE'(START_POS);
    localparam logic [WIDTH_COMPUTE-1:0] LP_ONE     = WIDTH_COMPUTE'(1);

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_dir;
    logic [WIDTH_STEP-1:0]    r_rem;
    logic [WIDTH_DIN-1:0]     r_din;
    logic [WIDTH_COMPUTE-1:0] r_laps;
    logic [WIDTH_COMPUTE-1:0] r_pos;
    logic [WIDTH_COMPUTE-1:0] r_zero;
    logic [WIDTH_COMPUTE-1:0] r_pass;
    logic [WIDTH_COMPUTE-1:0] r_ops;

    logic                     w_rem_ge;
    logic [WIDTH_COMPUTE-1:0] w_rem_c;
    logic [WIDTH_COMPUTE-1:0] w_sum;
    logic [WIDTH_COMPUTE-1:0] w_new_pos;
    logic                     w_cross;

    assign din_ready  = (r_state == IDLE);
    assign dout_valid = (r_state == DONE);
    assign w_rem_ge   = (r_rem >= LP_SIZE_S);
    assign w_rem_c    = WIDTH_COMPUTE'(r_rem);
    assign w_sum      = r_pos + w_rem_c;

    // After the divider the remainder is below DIAL_SIZE, so one correction suffices.
    always_comb begin
        w_new_pos = r_pos;
        w_cross   = 1'b0;
        if (!r_dir) begin
            w_cross   = (w_sum >= LP_SIZE_C);
            w_new_pos = w_cross ? (w_sum - LP_SIZE_C) : w_sum;
        end else begin
            w_cross   = ((w_rem_c > r_pos) && (r_pos != '0)) ||
                        ((w_rem_c == r_pos) && (w_rem_c != '0));
            w_new_pos = (w_rem_c <= r_pos) ? (r_pos - w_rem_c)
                                           : (r_pos + LP_SIZE_C - w_rem_c);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (din_valid) w_next = DIV;
            DIV:     if (!w_rem_ge) w_next = APPLY;
            APPLY:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (clear) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dir  <= 1'b0;
            r_rem  <= '0;
            r_din  <= '0;
            r_laps <= '0;
            r_pos  <= LP_START_C;
            r_zero <= '0;
            r_pass <= '0;
            r_ops  <= '0;
        end else if (clear) begin
            r_dir  <= 1'b0;
            r_rem  <= '0;
            r_din  <= '0;
            r_laps <= '0;
            r_pos  <= LP_START_C;
            r_zero <= '0;
            r_pass <= '0;
            r_ops  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (din_valid) begin
                        r_dir  <= din[WIDTH_STEP];
                        r_rem  <= din[WIDTH_STEP-1:0];
                        r_din  <= din;
                        r_laps <= '0;
                    end
                end
                DIV: begin
                    if (w_rem_ge) begin
                        r_rem  <= r_rem - LP_SIZE_S;
                        r_laps <= r_laps + LP_ONE;
                    end
                end
                APPLY: begin
                    r_pos  <= w_new_pos;
                    r_zero <= r_zero + ((w_new_pos == '0) ? LP_ONE : '0);
                    r_pass <= r_pass + r_laps + (w_cross ? LP_ONE : '0);
                    r_ops  <= r_ops + LP_ONE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dout = '0;
        case (sel)
            3'd0:    dout = WIDTH_DOUT'(r_din);
            3'd1:    dout = WIDTH_DOUT'(r_pos);
            3'd2:    dout = WIDTH_DOUT'(r_zero);
            3'd3:    dout = WIDTH_DOUT'(r_pass);
            3'd4:    dout = WIDTH_DOUT'(r_laps);
            3'd5:    dout = WIDTH_DOUT'(r_ops);
            default: dout = '0;
        endcase
    end

endmodule

// File: tb/tb_dial_coprocessor.sv
// Directed bench for dial_coprocessor with hand-computed dial positions and counts.
module tb_dial_coprocessor;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         clear = 1'b0;
    logic [2:0]   sel = 3'd0;
    logic [127:0] dout;
    logic         dout_valid;

    int assertCount = 0;
    int failCount = 0;

    dial_coprocessor dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .clear      (clear),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic readReg(input logic [2:0] s, output logic [127:0] v);
        sel = s;
        #1;
        v = dout;
    endtask

    task automatic checkRegs(input string tag, input int pos, input int zero,
                             input int pass, input int ops);
        logic [127:0] v;
        readReg(3'd1, v); checkOutput({tag, ".pos"}, v, 128'(pos));
        readReg(3'd2, v); checkOutput({tag, ".zero"}, v, 128'(zero));
        readReg(3'd3, v); checkOutput({tag, ".pass"}, v, 128'(pass));
        readReg(3'd5, v); checkOutput({tag, ".ops"}, v, 128'(ops));
    endtask

    task automatic doReset();
        rst = 1'b0;
        din_valid = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Entered just after the accepting edge; counts that edge as edge 1.
    task automatic waitDone(output int edges, output logic readyLowAll);
        edges = 1;
        readyLowAll = 1'b1;
        while (!dout_valid && edges < 5000) begin
            if (din_ready) readyLowAll = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
        if (!dout_valid) checkOutput("timeout", dout_valid, 1);
        @(posedge clk);
        #1;
        checkOutput("pulse_width", dout_valid, 0);
    endtask

    task automatic applyStimulus(input logic dir, input int mag, output int edges,
                                 output logic readyLowAll);
        logic [127:0] cmd;
        int guard;
        guard = 0;
        while (!din_ready && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        cmd = '0;
        cmd[15:0] = mag[15:0];
        cmd[16] = dir;
        din = cmd;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        waitDone(edges, readyLowAll);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] v;
        int edges;
        logic rdyLow;
        logic seqDir [10];
        int seqMag [10];
        logic sawValid;

        seqDir = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        seqMag = '{68, 30, 48, 5, 60, 55, 1, 99, 14, 82};

        // Reset state, with din_valid offered while reset is held.
        din_valid = 1'b1;
        din = 128'd7;
        #3;
        checkOutput("rst.ready", din_ready, 1);
        checkOutput("rst.valid", dout_valid, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rst.ready_held", din_ready, 1);
        checkRegs("rst", 50, 0, 0, 0);
        readReg(3'd0, v); checkOutput("rst.din", v, 0);
        readReg(3'd4, v); checkOutput("rst.laps", v, 0);
        doReset();

        // Ten-command sequence.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(seqDir[i], seqMag[i], edges, rdyLow);
            checkOutput($sformatf("seq%0d.latency", i), 128'(edges), 128'(seqMag[i] / 100 + 3));
        end
        checkRegs("seq", 32, 3, 6, 10);
        readReg(3'd0, v); checkOutput("seq.din", v, 128'd82 | (128'd1 << 16));
        readReg(3'd6, v); checkOutput("seq.sel6", v, 0);
        readReg(3'd7, v); checkOutput("seq.sel7", v, 0);

        // R1000: ten full laps back to the start position.
        doReset();
        applyStimulus(1'b0, 1000, edges, rdyLow);
        checkOutput("r1000.latency", 128'(edges), 13);
        checkOutput("r1000.ready_low", rdyLow, 1);
        readReg(3'd4, v); checkOutput("r1000.laps", v, 10);
        readReg(3'd0, v); checkOutput("r1000.din", v, 1000);
        checkRegs("r1000", 50, 0, 10, 1);

        // R50 lands on zero, then L0 at zero.
        doReset();
        applyStimulus(1'b0, 50, edges, rdyLow);
        applyStimulus(1'b1, 0, edges, rdyLow);
        checkRegs("r50l0", 0, 2, 1, 2);

        // L50 to zero, then L100 crossing only by its lap.
        doReset();
        applyStimulus(1'b1, 50, edges, rdyLow);
        applyStimulus(1'b1, 100, edges, rdyLow);
        checkOutput("l100.latency", 128'(edges), 4);
        readReg(3'd4, v); checkOutput("l100.laps", v, 1);
        checkRegs("l50l100", 0, 2, 2, 2);

        // Clear during DIV of R500 with the command still offered.
        doReset();
        din = 128'd500;
        din_valid = 1'b1;
        @(posedge clk); #1;
        checkOutput("clr.accepted", din_ready, 0);
        sawValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (dout_valid) sawValid = 1'b1;
        end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        if (dout_valid) sawValid = 1'b1;
        checkOutput("clr.no_valid", sawValid, 0);
        checkOutput("clr.ready", din_ready, 1);
        checkRegs("clr", 50, 0, 0, 0);
        readReg(3'd0, v); checkOutput("clr.din", v, 0);
        @(posedge clk); #1;
        din_valid = 1'b0;
        checkOutput("clr.reaccept", din_ready, 0);
        waitDone(edges, rdyLow);
        checkOutput("clr.latency", 128'(edges), 8);
        readReg(3'd4, v); checkOutput("clr.laps", v, 5);
        checkRegs("clr.after", 50, 0, 5, 1);

        // Asynchronous reset in the middle of APPLY.
        doReset();
        din = 128'd30;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        @(posedge clk); #1;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst.ready", din_ready, 1);
        checkOutput("arst.valid", dout_valid, 0);
        checkRegs("arst", 50, 0, 0, 0);
        readReg(3'd0, v); checkOutput("arst.din", v, 0);
        din_valid = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (dout_valid || !din_ready) sawValid = 1'b1;
        end
        din_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (dout_valid) sawValid = 1'b1;
        end
        checkOutput("arst.no_valid", sawValid, 0);
        checkRegs("arst.after", 50, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
